read_buf: RTL and testbench
===========================

READ_BUF -- requirements
Module: read_buf

Interface
REQ-001 SHALL have parameter ADDR_LMT, default 20, cache-line address width.
REQ-002 SHALL have parameter MDATA, default 14, request tag width.
REQ-003 SHALL have parameter CACHE_WIDTH, default 512, line width; only 512 is supported.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, in, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, in, 1: synchronous active-high reset.
REQ-007 Port start, in, 1: leaves IDLE.
REQ-008 Port rd_en, in, 1: user read request.
REQ-009 Port rd_addr, in, ADDR_LMT+4: word address; [ADDR_LMT+3:4] is the line, [3:0] is the 32-bit word offset.
REQ-010 Port rd_ready, out, 1: block can accept rd_en.
REQ-011 Port rd_data, out, 32: returned word.
REQ-012 Port rd_valid, out, 1: rd_data valid, one-cycle pulse.
REQ-013 Port invalidate, in, 1: drops the held line.
REQ-014 Port rd_req_addr, out, ADDR_LMT: line read request address.
REQ-015 Port rd_req_mdata, out, MDATA: request tag.
REQ-016 Port rd_req_en, out, 1: request strobe.
REQ-017 Port rd_req_almostfull, in, 1: request channel backpressure.
REQ-018 Port rd_rsp_valid, in, 1: response strobe.
REQ-019 Port rd_rsp_mdata, in, MDATA: response tag.
REQ-020 Port rd_rsp_data, in, CACHE_WIDTH: response line.

Function
REQ-021 SHALL implement states IDLE, READY, REQ, WAIT and RESP.
REQ-022 IDLE SHALL move to READY on start=1; all other inputs are ignored in IDLE.
REQ-023 rd_ready SHALL be 1 only in READY; rd_en is accepted only when rd_en=1 and rd_ready=1, and is ignored otherwise.
REQ-024 On acceptance, the block SHALL register the line address and offset from rd_addr.
REQ-025 A hit (line valid, tag matches, invalidate=0) SHALL give rd_valid=1 on the next cycle, with rd_data = line[offset*32 +: 32]; the block stays in READY.
REQ-026 A miss SHALL move to REQ.
REQ-027 In REQ, on a cycle with rd_req_almostfull=0, the block SHALL pulse rd_req_en for one cycle with rd_req_addr = registered line and rd_req_mdata = the tag counter, then move to WAIT.
REQ-028 While rd_req_almostfull=1, the block SHALL stay in REQ with rd_req_en=0.
REQ-029 In WAIT, a response with rd_rsp_valid=1 and rd_rsp_mdata equal to the tag counter SHALL latch rd_rsp_data into the line buffer and move to RESP.
REQ-030 Mismatched-tag responses, and any response outside WAIT, SHALL be ignored.
REQ-031 RESP SHALL drive rd_valid=1 for one cycle with the selected word, increment the tag counter (wrapping 2^MDATA-1 -> 0) and return to READY.
REQ-032 Outstanding requests SHALL be at most one.
REQ-033 invalidate=1 SHALL clear line-valid on the same edge; if it coincides with rd_en, the read is treated as a miss.
REQ-034 invalidate=1 during REQ/WAIT SHALL still complete the read, but the filled line SHALL be left invalid.
REQ-035 Word offset 0 SHALL map to bits [31:0]; offset 15 SHALL map to bits [511:480].
REQ-036 rd_req_addr and rd_req_mdata SHALL hold their last values when rd_req_en=0.

Reset
REQ-037 Reset SHALL force IDLE.
REQ-038 Reset SHALL clear rd_ready, rd_valid, rd_req_en, rd_data, rd_req_addr, rd_req_mdata, the tag counter and line-valid.
REQ-039 Reset mid-transaction SHALL abandon the read with no rd_valid; late responses SHALL be ignored in IDLE.

Configuration
REQ-040 Macro READ_BUF_LINE_CACHE_EN defined: the hit path of REQ-025 SHALL be active.
REQ-041 Macro READ_BUF_LINE_CACHE_EN undefined: every accepted read SHALL be a miss, line-valid SHALL stay 0, and invalidate SHALL have no effect.

Verification
REQ-042 Miss then return: reset, start, rd_en with rd_addr=0x00013 -> rd_req_en with rd_req_addr=0x00001 and mdata=0; respond with mdata=0 and word3=0xDEADBEEF -> rd_valid with rd_data=0xDEADBEEF.
REQ-043 Hit (macro on): after REQ-042, rd_addr=0x0001F -> rd_valid the next cycle with word15 and no rd_req_en; with the macro off -> a new request with mdata=1.
REQ-044 Backpressure: rd_req_almostfull=1 for 10 cycles after a miss -> rd_req_en=0 throughout; a single pulse once it drops.
REQ-045 Tag filter: in WAIT, respond first with mdata=5 and then with the expected tag -> only the second response is latched and a single rd_valid occurs.
REQ-046 Reset in WAIT, then start, then a stale response arrives -> no rd_valid, and the state is READY.
REQ-047 Invalidate with rd_en on a cached line -> a miss request is issued; invalidate during WAIT -> data is returned, and the next same-line read misses.

Source files
------------

// File: rtl/read_buf.sv
// Single-line read buffer: turns 32-bit word reads into cache-line requests with one outstanding miss.
// Define READ_BUF_LINE_CACHE_EN to serve reads that hit the held line without a new request.
module read_buf #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rd_en,
    input  logic [ADDR_LMT+3:0]    rd_addr,
    output logic                   rd_ready,
    output logic [31:0]            rd_data,
    output logic                   rd_valid,
    input  logic                   invalidate,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data
);

`ifdef READ_BUF_LINE_CACHE_EN
    localparam logic CACHE_EN = 1'b1;
`else
    localparam logic CACHE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_LMT-1:0]    line_q, line_d;
    logic [3:0]             off_q, off_d;
    logic [MDATA-1:0]       tag_cnt_q, tag_cnt_d;
    logic                   line_valid_q, line_valid_d;
    logic                   inval_seen_q, inval_seen_d;
    logic [CACHE_WIDTH-1:0] line_buf_q, line_buf_d;
    logic                   rd_ready_q, rd_ready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   rd_req_en_q, rd_req_en_d;
    logic [ADDR_LMT-1:0]    rd_req_addr_q, rd_req_addr_d;
    logic [MDATA-1:0]       rd_req_mdata_q, rd_req_mdata_d;
    logic                   accept_s;
    logic                   hit_s;
    logic                   line_valid_s;

    // Word 0 occupies the least significant 32 bits of the line.
    function automatic logic [31:0] word_sel(input logic [CACHE_WIDTH-1:0] line, input logic [3:0] off);
        return line[{off, 5'd0} +: 32];
    endfunction

    // Next-state and next-output computation for the read FSM.
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        off_d          = off_q;
        tag_cnt_d      = tag_cnt_q;
        inval_seen_d   = inval_seen_q;
        line_buf_d     = line_buf_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        rd_req_en_d    = 1'b0;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        line_valid_s   = line_valid_q;
        accept_s       = rd_en & rd_ready_q;
        hit_s          = CACHE_EN & line_valid_q & ~invalidate & (rd_addr[ADDR_LMT+3:4] == line_q);

        case (state_q)
            S_IDLE: begin
                state_d = start ? S_READY : S_IDLE;
            end
            S_READY: begin
                if (accept_s) begin
                    line_d       = rd_addr[ADDR_LMT+3:4];
                    off_d        = rd_addr[3:0];
                    inval_seen_d = 1'b0;
                    if (hit_s) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = word_sel(line_buf_q, rd_addr[3:0]);
                    end else begin
                        // The held tag is overwritten, so the old line can no longer be trusted.
                        line_valid_s = 1'b0;
                        state_d      = S_REQ;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_REQ: begin
                inval_seen_d = inval_seen_q | invalidate;
                if (!rd_req_almostfull) begin
                    rd_req_en_d    = 1'b1;
                    rd_req_addr_d  = line_q;
                    rd_req_mdata_d = tag_cnt_q;
                    state_d        = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                inval_seen_d = inval_seen_q | invalidate;
                if (rd_rsp_valid && (rd_rsp_mdata == tag_cnt_q)) begin
                    line_buf_d = rd_rsp_data;
                    state_d    = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                rd_valid_d   = 1'b1;
                rd_data_d    = word_sel(line_buf_q, off_q);
                tag_cnt_d    = tag_cnt_q + {{(MDATA-1){1'b0}}, 1'b1};
                line_valid_s = CACHE_EN & ~inval_seen_q;
                state_d      = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        line_valid_d = CACHE_EN & line_valid_s & ~invalidate;
        rd_ready_d   = (state_d == S_READY);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            line_q         <= {ADDR_LMT{1'b0}};
            off_q          <= 4'd0;
            tag_cnt_q      <= {MDATA{1'b0}};
            line_valid_q   <= 1'b0;
            inval_seen_q   <= 1'b0;
            line_buf_q     <= {CACHE_WIDTH{1'b0}};
            rd_ready_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 32'd0;
            rd_req_en_q    <= 1'b0;
            rd_req_addr_q  <= {ADDR_LMT{1'b0}};
            rd_req_mdata_q <= {MDATA{1'b0}};
        end else begin
            state_q        <= state_d;
            line_q         <= line_d;
            off_q          <= off_d;
            tag_cnt_q      <= tag_cnt_d;
            line_valid_q   <= line_valid_d;
            inval_seen_q   <= inval_seen_d;
            line_buf_q     <= line_buf_d;
            rd_ready_q     <= rd_ready_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_req_en_q    <= rd_req_en_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
        end
    end

    assign rd_ready     = rd_ready_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_req_en    = rd_req_en_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_mdata = rd_req_mdata_q;

endmodule

// File: tb/tb_read_buf.sv
// Directed scoreboard bench for read_buf; expectations follow READ_BUF_LINE_CACHE_EN when defined.
module tb_read_buf;
    localparam int ADDR_LMT = 20;
    localparam int MDATA    = 14;
    localparam int CW       = 512;
`ifdef READ_BUF_LINE_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset, start, rd_en, invalidate;
    logic [ADDR_LMT+3:0] rd_addr;
    logic                rd_ready, rd_valid, rd_req_en;
    logic [31:0]         rd_data;
    logic [ADDR_LMT-1:0] rd_req_addr;
    logic [MDATA-1:0]    rd_req_mdata;
    logic                rd_req_almostfull, rd_rsp_valid;
    logic [MDATA-1:0]    rd_rsp_mdata;
    logic [CW-1:0]       rd_rsp_data;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_req    = 0;

    logic [31:0]                exp_data_q[$];
    logic [ADDR_LMT+MDATA-1:0]  exp_req_q[$];
    logic [MDATA-1:0]           exp_tag;
    bit                         model_valid;
    logic [ADDR_LMT-1:0]        model_addr;
    logic [CW-1:0]              model_line;

    read_buf #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .invalidate(invalidate),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample outputs and score any pulses against the queues.
    task automatic tick();
        logic [31:0]               ed;
        logic [ADDR_LMT+MDATA-1:0] er;
        @(posedge clk);
        #1;
        if (rd_valid === 1'b1) begin
            n_valid++;
            if (exp_data_q.size() == 0) check("unexpected_rd_valid", 64'd1, 64'd0);
            else begin
                ed = exp_data_q.pop_front();
                check("rd_data", {32'd0, rd_data}, {32'd0, ed});
            end
        end
        if (rd_req_en === 1'b1) begin
            n_req++;
            if (exp_req_q.size() == 0) check("unexpected_rd_req_en", 64'd1, 64'd0);
            else begin
                er = exp_req_q.pop_front();
                check("rd_req_addr_mdata", {30'd0, rd_req_addr, rd_req_mdata}, {30'd0, er});
            end
        end
    endtask

    task automatic wait_req(input int r0);
        for (int i = 0; i < 50 && n_req == r0; i++) tick();
        check("req_timeout", {63'd0, n_req != r0}, 64'd1);
    endtask

    task automatic wait_valid(input int v0);
        for (int i = 0; i < 50 && n_valid == v0; i++) tick();
        check("valid_timeout", {63'd0, n_valid != v0}, 64'd1);
    endtask

    function automatic logic [CW-1:0] mk_line(input logic [15:0] seed);
        logic [CW-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = {seed, 12'h0A5, i[3:0]};
        return l;
    endfunction

    // One user read; hit or miss is decided by the bench's own line model.
    task automatic read_op(input logic [ADDR_LMT+3:0] addr, input logic [CW-1:0] fill,
                           input bit inval_en, input bit inval_wait, input int bp, input bit bad_tag);
        int                  v0, r0;
        logic [ADDR_LMT-1:0] ln;
        logic [3:0]          off;
        bit                  hit;
        ln  = addr[ADDR_LMT+3:4];
        off = addr[3:0];
        hit = CACHE_EN && model_valid && (model_addr == ln) && !inval_en;
        v0  = n_valid;
        r0  = n_req;
        rd_addr           = addr;
        rd_en             = 1'b1;
        invalidate        = inval_en;
        rd_req_almostfull = (bp > 0) ? 1'b1 : 1'b0;
        if (hit) begin
            exp_data_q.push_back(model_line[off*32 +: 32]);
            tick();
            rd_en = 1'b0; invalidate = 1'b0;
            check("hit_valid_next_cycle", 64'(n_valid - v0), 64'd1);
            check("hit_no_request", 64'(n_req - r0), 64'd0);
        end else begin
            exp_req_q.push_back({ln, exp_tag});
            tick();
            rd_en = 1'b0; invalidate = 1'b0;
            for (int i = 0; i < bp; i++) begin
                tick();
                check("bp_req_en_low", {63'd0, rd_req_en}, 64'd0);
            end
            rd_req_almostfull = 1'b0;
            wait_req(r0);
            if (bp > 0) begin
                tick();
                check("req_single_pulse", 64'(n_req - r0), 64'd1);
                check("req_fields_hold", {30'd0, rd_req_addr, rd_req_mdata}, {30'd0, ln, exp_tag});
            end
            if (inval_wait) begin
                invalidate = 1'b1; tick(); invalidate = 1'b0;
            end
            if (bad_tag) begin
                rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd5; rd_rsp_data = ~fill;
                tick();
                rd_rsp_valid = 1'b0;
                repeat (3) tick();
                check("bad_tag_ignored", 64'(n_valid - v0), 64'd0);
            end
            exp_data_q.push_back(fill[off*32 +: 32]);
            rd_rsp_valid = 1'b1; rd_rsp_mdata = exp_tag; rd_rsp_data = fill;
            tick();
            rd_rsp_valid = 1'b0;
            wait_valid(v0);
            tick();
            check("single_rd_valid", 64'(n_valid - v0), 64'd1);
            exp_tag     = exp_tag + 14'd1;
            model_valid = CACHE_EN && !inval_wait;
            model_addr  = ln;
            model_line  = fill;
        end
    endtask

    initial begin
        logic [CW-1:0] l1;
        int            v0, r0;
        reset = 1'b1; start = 1'b0; rd_en = 1'b0; invalidate = 1'b0; rd_addr = 24'd0;
        rd_req_almostfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = 14'd0; rd_rsp_data = '0;
        exp_tag = 14'd0; model_valid = 1'b0; model_addr = 20'd0; model_line = '0;
        repeat (3) tick();
        check("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_req_en", {63'd0, rd_req_en}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_req_addr_mdata", {30'd0, rd_req_addr, rd_req_mdata}, 64'd0);

        reset = 1'b0; rd_en = 1'b1; rd_addr = 24'h00013; invalidate = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0; invalidate = 1'b0;
        check("idle_ready_low", {63'd0, rd_ready}, 64'd0);
        check("idle_no_request", 64'(n_req), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("ready_after_start", {63'd0, rd_ready}, 64'd1);

        l1 = mk_line(16'h0001);
        l1[3*32 +: 32] = 32'hDEADBEEF;
        read_op(24'h00013, l1, 1'b0, 1'b0, 0, 1'b0);
        read_op(24'h0001F, mk_line(16'h0002), 1'b0, 1'b0, 0, 1'b0);
        read_op(24'h00020, mk_line(16'h0003), 1'b0, 1'b0, 10, 1'b1);
        read_op(24'h00027, mk_line(16'h0004), 1'b1, 1'b0, 0, 1'b0);
        read_op(24'h00035, mk_line(16'h0005), 1'b0, 1'b1, 0, 1'b0);
        read_op(24'h00030, mk_line(16'h0006), 1'b0, 1'b0, 0, 1'b0);
        read_op(24'h0003A, mk_line(16'h0007), 1'b0, 1'b0, 0, 1'b0);

        v0 = n_valid;
        r0 = n_req;
        exp_req_q.push_back({20'h00004, exp_tag});
        rd_addr = 24'h00040; rd_en = 1'b1; tick(); rd_en = 1'b0;
        wait_req(r0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_rd_ready", {63'd0, rd_ready}, 64'd0);
        check("midrst_rd_data", {32'd0, rd_data}, 64'd0);
        check("midrst_req_mdata", {50'd0, rd_req_mdata}, 64'd0);
        exp_tag = 14'd0; model_valid = 1'b0;
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd0; rd_rsp_data = mk_line(16'h00EE);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rd_rsp_valid = 1'b0;
        repeat (3) tick();
        check("stale_rsp_no_valid", 64'(n_valid - v0), 64'd0);
        check("stale_rsp_state_ready", {63'd0, rd_ready}, 64'd1);
        read_op(24'h00041, mk_line(16'h0008), 1'b0, 1'b0, 0, 1'b0);

        check("sb_data_drained", 64'(exp_data_q.size()), 64'd0);
        check("sb_req_drained", 64'(exp_req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
